// File: rtl/write_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : write_unit_pkg
// Description : Shared state encoding and default widths for the write unit.
// Revision    : 1.0 - initial release
// ============================================================================
package write_unit_pkg;

  // Default geometry: 256 words of 32 bits
  localparam int DEFAULT_ADDRESS_WIDTH = 8;
  localparam int DEFAULT_DATA_WIDTH    = 32;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage : write_unit_pkg
`default_nettype wire

// File: rtl/write_unit_ram.sv
`default_nettype none
// ============================================================================
// Module      : write_unit_ram
// Description : Simple dual-port synchronous RAM, one write port and one
//               registered read port with read-before-write behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module write_unit_ram
  import write_unit_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic [ADDRESS_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0]    i_wdata,
  input  logic [ADDRESS_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0]    o_rdata
);

  localparam int c_depth = 1 << ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [0:c_depth-1];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Write port: contents are deliberately left uncleared by reset
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: non-blocking sample gives the pre-write contents on a collision
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule : write_unit_ram
`default_nettype wire

// File: rtl/write_unit.sv
`default_nettype none
// ============================================================================
// Module      : write_unit
// Description : Start/ready write controller storing words at sequential
//               addresses into an internal RAM, with a debug read port.
// Revision    : 1.0 - initial release
// ============================================================================
module write_unit
  import write_unit_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [DATA_WIDTH-1:0]    data,
  output logic                     ready,
  output logic [ADDRESS_WIDTH:0]   count,
  output logic                     full,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  // Depth expressed in the count width so the full compare needs no casts
  localparam logic [ADDRESS_WIDTH:0] c_depth = {1'b1, {ADDRESS_WIDTH{1'b0}}};
  localparam logic [ADDRESS_WIDTH:0] c_one   = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

  state_t                   r_state;
  logic [ADDRESS_WIDTH-1:0] r_wr_ptr;
  logic [ADDRESS_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0]    r_data_q;
  logic                     r_ready;
  logic                     r_full;

  logic                     w_we;
  logic [ADDRESS_WIDTH:0]   w_count_inc;

  // A reset landing on the WRITE cycle must abandon that word
  assign w_we        = (r_state == ST_WRITE) && !reset;
  assign w_count_inc = r_count + c_one;

  // Controller FSM with pointer, counter, holding register and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_data_q <= '0;
      r_ready  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_data_q <= data;
            r_state  <= ST_WRITE;
            r_ready  <= 1'b0;
          end
        end
        ST_WRITE: begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          r_count  <= w_count_inc;
          if (w_count_inc == c_depth) begin
            r_state <= ST_FULL;
            r_full  <= 1'b1;
            r_ready <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end
        end
        ST_FULL: begin
          r_ready <= 1'b0;
          r_full  <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_full  <= 1'b0;
        end
      endcase
    end
  end

  write_unit_ram #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (reset),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (r_data_q),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );

  assign ready = r_ready;
  assign full  = r_full;
  assign count = r_count;

endmodule : write_unit
`default_nettype wire

// File: tb/tb_write_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_write_unit
// Description : Directed self-checking bench for write_unit (default depth
//               instance plus a 4-word instance for the fill boundary).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_write_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-size instance
  logic        reset = 1'b0, start = 1'b0;
  logic [31:0] data = '0;
  logic        ready, full;
  logic [8:0]  count;
  logic [7:0]  rd_addr = '0;
  logic [31:0] rd_data;

  // Four-word instance
  logic        s_reset = 1'b0, s_start = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready, s_full;
  logic [2:0]  s_count;
  logic [1:0]  s_rd_addr = '0;
  logic [31:0] s_rd_data;

  int n_total = 0;
  int n_bad   = 0;

  write_unit #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .data(data), .ready(ready),
    .count(count), .full(full), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  write_unit #(.ADDRESS_WIDTH(2), .DATA_WIDTH(32)) dut_s (
    .clk(clk), .reset(s_reset), .start(s_start), .data(s_data), .ready(s_ready),
    .count(s_count), .full(s_full), .rd_addr(s_rd_addr), .rd_data(s_rd_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // One accepted word on the default instance: accept edge, then write edge
  task automatic write_word(input logic [31:0] w);
    start = 1'b1; data = w;
    step();
    start = 1'b0;
    step();
  endtask

  task automatic read_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
    rd_addr = a;
    step();
    check(tag, {32'h0, rd_data}, {32'h0, exp});
  endtask

  task automatic s_read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    s_rd_addr = a;
    step();
    check(tag, {32'h0, s_rd_data}, {32'h0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] vals [4];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;

    // ---- Reset state
    reset = 1'b1; s_reset = 1'b1;
    step();
    check("rst_ready", ready, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_rd_data", rd_data, 0);
    check("s_rst_ready", s_ready, 1);
    reset = 1'b0; s_reset = 1'b0;

    // ---- Single write
    start = 1'b1; data = 32'h5;
    step();
    check("single_busy", ready, 0);
    start = 1'b0;
    step();
    check("single_ready", ready, 1);
    check("single_count", count, 1);
    read_check("single_rd", 8'd0, 32'h5);

    // ---- Alternating stream: start toggles, data advances every 2 cycles
    do_reset();
    for (int i = 0; i < 8; i++) begin
      start = (i % 2 == 0);
      data  = 32'(i / 2 + 1);
      step();
    end
    start = 1'b0;
    check("alt_count", count, 4);
    check("alt_ready", ready, 1);
    for (int i = 0; i < 4; i++)
      read_check($sformatf("alt_mem%0d", i), 8'(i), 32'(i + 1));

    // ---- Start held high while busy
    do_reset();
    start = 1'b1; data = 32'hA; step();
    check("busy_e1_ready", ready, 0);
    data = 32'hB; step();
    check("busy_e2_ready", ready, 1);
    data = 32'hC; step();
    start = 1'b0; step();
    check("busy_count", count, 2);
    read_check("busy_mem0", 8'd0, 32'hA);
    read_check("busy_mem1", 8'd1, 32'hC);

    // ---- Fill the four-word instance
    for (int i = 0; i < 4; i++) begin
      s_start = 1'b1; s_data = vals[i]; step();
      s_start = 1'b0; step();
    end
    check("fill_count", s_count, 4);
    check("fill_full", s_full, 1);
    check("fill_ready", s_ready, 0);
    s_start = 1'b1; s_data = 32'h55; step(); step();
    s_start = 1'b0; step();
    check("fill5_count", s_count, 4);
    check("fill5_full", s_full, 1);
    for (int i = 0; i < 4; i++)
      s_read_check($sformatf("fill_mem%0d", i), 2'(i), vals[i]);
    s_reset = 1'b1; step(); s_reset = 1'b0;
    check("fill_rst_count", s_count, 0);
    check("fill_rst_ready", s_ready, 1);
    check("fill_rst_full", s_full, 0);

    // ---- Reset during the WRITE cycle
    do_reset();
    write_word(32'h77);
    check("mid_pre_count", count, 1);
    start = 1'b1; data = 32'h99; step();
    check("mid_in_write", ready, 0);
    start = 1'b0; reset = 1'b1; step();
    reset = 1'b0;
    check("mid_count", count, 0);
    check("mid_ready", ready, 1);
    // Next word goes to address 0; reading it during its write returns old data
    rd_addr = 8'd0;
    start = 1'b1; data = 32'h42; step();
    start = 1'b0; step();
    check("rbw_old", rd_data, 32'h77);
    step();
    check("rbw_new", rd_data, 32'h42);
    check("mid_next_count", count, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_write_unit
`default_nettype wire
